// File: rtl/load_cell_a2d_seq.sv
`default_nettype none
// ============================================================================
// Module   : load_cell_a2d_seq
// Purpose  : SPI master for a 12-bit, 8-channel ADC. Each round converts the
//            left load cell, right load cell and battery channels in turn.
//            Every channel takes two 16-bit frames: the first carries the
//            channel command, and the second repeats it and returns the result.
//            The results are held in registers, and vld pulses for one clock
//            when the round completes.
// Ports    : clk, rst (sync, active high)
//            nxt              - one-clock pulse, starts a round when idle
//            MISO             - ADC serial data out
//            SS_n, SCLK, MOSI - SPI chip select (low), clock (idles high), data
//            lft_ld, rght_ld, batt - latest 12-bit results
//            vld              - one-clock pulse, all three results updated
// Options  : define LD_FILT_EN to IIR-filter lft_ld / rght_ld
//            (new = old + ((sample - old) >>> 2), first sample loads directly)
// Revision : 1.0 - initial release
// ============================================================================
module load_cell_a2d_seq #(
    parameter int         SCLK_DIV = 32,
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] BATT_CH  = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld
);

    localparam int               HALF     = SCLK_DIV / 2;
    localparam int               DIVW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(HALF - 1);
    // Segment 0 is the lead-in high time. Odd segments 1..31 are SCLK low and
    // even segments 2..32 are SCLK high. Segment 33 is a one-clock tail
    // before SS_n is released.
    localparam logic [5:0]       SEG_LAST_HI = 6'd32;
    localparam logic [5:0]       SEG_TAIL    = 6'd33;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_GAP   = 3'd2,
        S_RESP  = 3'd3,
        S_STORE = 3'd4
    } state_t;

    state_t          state_q;
    logic [1:0]      idx_q;
    logic [DIVW-1:0] div_q;
    logic [5:0]      seg_q;
    logic [14:0]     tx_q;
    logic [15:0]     rx_q;
    logic            ss_n_q, sclk_q, mosi_q, vld_q;
    logic [11:0]     lft_q, rght_q, batt_q;

    logic            start_d;
    logic [1:0]      start_idx_d;
    logic [15:0]     start_cmd_d;
    logic [11:0]     lft_d, rght_d;
    logic            w_unused_rx;

    function automatic logic [15:0] cmd_for(input logic [1:0] i);
        logic [2:0] ch;
        case (i)
            2'd0:    ch = LFT_CH;
            2'd1:    ch = RGHT_CH;
            default: ch = BATT_CH;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    // A frame is launched from IDLE on nxt, at the end of GAP, and from
    // STORE whenever more channels remain in the round. nxt is ignored in
    // the clock where vld is high, because that clock is already in IDLE.
    always_comb begin
        start_d     = 1'b0;
        start_idx_d = idx_q;
        case (state_q)
            S_IDLE: begin
                start_d     = nxt && !vld_q;
                start_idx_d = 2'd0;
            end
            S_GAP:   start_d = (div_q == DIV_LAST);
            S_STORE: begin
                start_d     = (idx_q != 2'd2);
                start_idx_d = idx_q + 2'd1;
            end
            default: start_d = 1'b0;
        endcase
        start_cmd_d = cmd_for(start_idx_d);
    end

    assign w_unused_rx = &{1'b0, rx_q[15:12]};

`ifdef LD_FILT_EN
    logic prim_lft_q, prim_rght_q;

    function automatic logic [11:0] iir(input logic [11:0] old, input logic [11:0] smp);
        logic signed [12:0] diff;
        logic signed [12:0] step;
        diff = $signed({1'b0, smp}) - $signed({1'b0, old});
        step = diff >>> 2;
        // The result always stays between old and the sample, so truncating
        // to 12 bits never wraps.
        return old + step[11:0];
    endfunction

    always_comb begin
        lft_d  = prim_lft_q  ? iir(lft_q,  rx_q[11:0]) : rx_q[11:0];
        rght_d = prim_rght_q ? iir(rght_q, rx_q[11:0]) : rx_q[11:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prim_lft_q  <= 1'b0;
            prim_rght_q <= 1'b0;
        end else if (state_q == S_STORE) begin
            if (idx_q == 2'd0) prim_lft_q  <= 1'b1;
            if (idx_q == 2'd1) prim_rght_q <= 1'b1;
        end
    end
`else
    always_comb begin
        lft_d  = rx_q[11:0];
        rght_d = rx_q[11:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            div_q   <= '0;
            seg_q   <= 6'd0;
            tx_q    <= 15'h0000;
            rx_q    <= 16'h0000;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            vld_q   <= 1'b0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) state_q <= S_CMD;
                end
                S_CMD, S_RESP: begin
                    if (seg_q == SEG_TAIL) begin
                        ss_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        div_q   <= '0;
                        state_q <= (state_q == S_CMD) ? S_GAP : S_STORE;
                    end else if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        seg_q <= seg_q + 6'd1;
                        if (!seg_q[0]) begin
                            // Entering a low segment is a falling edge. The
                            // first fall keeps bit 15, which was driven when
                            // SS_n fell.
                            if (seg_q != SEG_LAST_HI) begin
                                sclk_q <= 1'b0;
                                if (seg_q != 6'd0) begin
                                    mosi_q <= tx_q[14];
                                    tx_q   <= {tx_q[13:0], 1'b0};
                                end
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[14:0], MISO};
                        end
                    end else begin
                        div_q <= div_q + DIVW'(1);
                    end
                end
                S_GAP: begin
                    if (div_q == DIV_LAST) state_q <= S_RESP;
                    else                   div_q   <= div_q + DIVW'(1);
                end
                S_STORE: begin
                    case (idx_q)
                        2'd0:    lft_q  <= lft_d;
                        2'd1:    rght_q <= rght_d;
                        default: batt_q <= rx_q[11:0];
                    endcase
                    if (idx_q == 2'd2) begin
                        vld_q   <= 1'b1;
                        idx_q   <= 2'd0;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= S_CMD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (start_d) begin
                ss_n_q <= 1'b0;
                sclk_q <= 1'b1;
                mosi_q <= start_cmd_d[15];
                tx_q   <= start_cmd_d[14:0];
                seg_q  <= 6'd0;
                div_q  <= '0;
            end
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;
    assign vld     = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_load_cell_a2d_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_cell_a2d_seq
// Purpose  : Self-checking bench for load_cell_a2d_seq. An ADC model answers
//            each frame with the channel commanded in the previous frame. A
//            monitor checks the frame and bit timing. Each round is checked
//            against a reference model of the stored results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_cell_a2d_seq;

    localparam int SCLK_DIV = 32;
    localparam int HALF     = SCLK_DIV / 2;
    localparam int FRAME    = HALF + 16 * SCLK_DIV + 1;
    localparam int LAT      = 1 + 3 * (2 * FRAME + HALF + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, vld;
    logic [11:0] lft_ld, rght_ld, batt;

    load_cell_a2d_seq #(
        .SCLK_DIV (SCLK_DIV),
        .LFT_CH   (3'd0),
        .RGHT_CH  (3'd4),
        .BATT_CH  (3'd5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .nxt     (nxt),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .lft_ld  (lft_ld),
        .rght_ld (rght_ld),
        .batt    (batt),
        .vld     (vld)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ADC model and bus monitor ----------------
    logic [11:0] adc_val [8];
    logic [15:0] cmds [$];
    logic [15:0] cmd_sh = 16'h0, resp_sh = 16'h0;
    logic [2:0]  last_ch = 3'd0;
    logic        p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
    int          rise_cnt = 0, lo_len = 0, hi_len = 0, sclk_hi = 0;
    int          frame_in_round = 0;
    int          vld_cnt = 0;

    always @(negedge clk) begin
        if (vld === 1'b1) vld_cnt++;
        if (rst) begin
            p_ss = 1'b1; p_sclk = 1'b1; p_mosi = 1'b0;
            rise_cnt = 0; MISO = 1'b0;
        end else begin
            if (p_ss && !SS_n) begin
                // Odd frame count means the command frame just ended: gap.
                if (frame_in_round % 2 == 1) chk("gap_len", hi_len, HALF);
                rise_cnt = 0;
                lo_len   = 1;
                resp_sh  = {4'hA, adc_val[last_ch]};
                MISO     = resp_sh[15];
            end else if (!p_ss && SS_n) begin
                chk("frame_len", lo_len, FRAME);
                if (rise_cnt == 16) begin
                    cmds.push_back(cmd_sh);
                    last_ch = cmd_sh[13:11];
                end
                frame_in_round++;
                hi_len = 1;
                MISO   = 1'b0;
            end else if (!SS_n) begin
                lo_len++;
                if (!p_sclk && SCLK) begin
                    chk("mosi_stable", MOSI, p_mosi);
                    cmd_sh = {cmd_sh[14:0], MOSI};
                    rise_cnt++;
                    sclk_hi = 1;
                end else if (p_sclk && !SCLK) begin
                    if (rise_cnt > 0) begin
                        chk("sclk_high", sclk_hi, HALF);
                        resp_sh = resp_sh << 1;
                        MISO    = resp_sh[15];
                    end
                end else if (SCLK) begin
                    sclk_hi++;
                end
            end else begin
                hi_len++;
            end
            p_ss = SS_n; p_sclk = SCLK; p_mosi = MOSI;
        end
    end

    // ---------------- reference model ----------------
    logic [11:0] m_lft = 12'h0, m_rght = 12'h0, m_batt = 12'h0;
    bit          m_prim_l = 0, m_prim_r = 0;

    function automatic logic [11:0] ref_filt(input logic [11:0] old, input logic [11:0] s);
        int d, step;
        d    = int'(s) - int'(old);
        step = (d >= 0) ? d / 4 : -((-d + 3) / 4);   // floor(d/4)
        return 12'(int'(old) + step);
    endfunction

    task automatic model_round(input logic [11:0] c0, input logic [11:0] c4, input logic [11:0] c5);
`ifdef LD_FILT_EN
        m_lft    = m_prim_l ? ref_filt(m_lft, c0)  : c0;
        m_rght   = m_prim_r ? ref_filt(m_rght, c4) : c4;
        m_prim_l = 1;
        m_prim_r = 1;
`else
        m_lft  = c0;
        m_rght = c4;
`endif
        m_batt = c5;
    endtask

    task automatic model_reset();
        m_lft = 12'h0; m_rght = 12'h0; m_batt = 12'h0;
        m_prim_l = 0; m_prim_r = 0;
    endtask

    // ---------------- round driver ----------------
    logic [15:0] exp_cmd [6];

    task automatic run_round(input logic [11:0] c0, input logic [11:0] c4, input logic [11:0] c5,
                             input logic [11:0] el, input logic [11:0] er, input logic [11:0] eb,
                             input logic [11:0] ol, input logic [11:0] orr, input logic [11:0] ob,
                             input bit hold_chk, input bit busy);
        int k, v0;
        adc_val[0] = c0; adc_val[4] = c4; adc_val[5] = c5;
        cmds.delete();
        frame_in_round = 0;
        v0 = vld_cnt;
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        k = 1;
        while (vld !== 1'b1 && k < LAT + 200) begin
            if (hold_chk && k == 600) begin
                chk("hold_lft", lft_ld, ol);
                chk("hold_rght", rght_ld, orr);
                chk("hold_batt", batt, ob);
            end
            @(negedge clk);
            nxt = busy && (k % 100 == 0);
            k++;
        end
        chk("latency", k, LAT);
        chk("lft_ld", lft_ld, el);
        chk("rght_ld", rght_ld, er);
        chk("batt", batt, eb);
        // nxt coincident with vld must be ignored
        nxt = busy;
        @(negedge clk); nxt = 1'b0;
        chk("vld_width", vld, 1'b0);
        chk("vld_count", vld_cnt - v0, 1);
        chk("frame_count", cmds.size(), 6);
        for (int i = 0; i < 6 && i < cmds.size(); i++) chk("mosi_cmd", cmds[i], exp_cmd[i]);
        if (busy) begin
            k = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (SS_n !== 1'b1) k++;
            end
            chk("busy_no_restart", k, 0);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_ss_n", SS_n, 1'b1);
        chk("rst_sclk", SCLK, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_vld", vld, 1'b0);
        chk("rst_lft", lft_ld, 12'h000);
        chk("rst_rght", rght_ld, 12'h000);
        chk("rst_batt", batt, 12'h000);
    endtask

    typedef struct {
        logic [11:0] c0, c4, c5;
        logic [11:0] e_l, e_r, e_b;
    } vec_t;

    vec_t        tbl [4];
    logic [11:0] ol, orr, ob, r0, r4, r5;
    logic [11:0] filt_exp [3];

    initial begin
        exp_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
`ifdef LD_FILT_EN
        filt_exp = '{12'h400, 12'h300, 12'h240};
`else
        filt_exp = '{12'h400, 12'h000, 12'h000};
`endif
        tbl[0].c0 = 12'h400; tbl[0].c4 = 12'h3F0; tbl[0].c5 = 12'hC00;
        tbl[1].c0 = 12'hFFF; tbl[1].c4 = 12'h000; tbl[1].c5 = 12'hFFF;
        tbl[2].c0 = 12'h000; tbl[2].c4 = 12'hFFF; tbl[2].c5 = 12'h001;
        tbl[3].c0 = 12'h123; tbl[3].c4 = 12'h456; tbl[3].c5 = 12'h789;
        for (int i = 0; i < 4; i++) begin
            model_round(tbl[i].c0, tbl[i].c4, tbl[i].c5);
            tbl[i].e_l = m_lft; tbl[i].e_r = m_rght; tbl[i].e_b = m_batt;
        end

        // Reset at start
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven rounds
        for (int i = 0; i < 4; i++) begin
            ol  = (i == 0) ? 12'h000 : tbl[i-1].e_l;
            orr = (i == 0) ? 12'h000 : tbl[i-1].e_r;
            ob  = (i == 0) ? 12'h000 : tbl[i-1].e_b;
            run_round(tbl[i].c0, tbl[i].c4, tbl[i].c5, tbl[i].e_l, tbl[i].e_r, tbl[i].e_b,
                      ol, orr, ob, 1'b0, 1'b0);
        end

        // Hold: ch0 becomes 0x100 after 0x400 is stored
        ol = m_lft; orr = m_rght; ob = m_batt;
        model_round(12'h400, 12'h3F0, 12'hC00);
        run_round(12'h400, 12'h3F0, 12'hC00, m_lft, m_rght, m_batt, ol, orr, ob, 1'b0, 1'b0);
        ol = m_lft; orr = m_rght; ob = m_batt;
        model_round(12'h100, 12'h3F0, 12'hC00);
        run_round(12'h100, 12'h3F0, 12'hC00, m_lft, m_rght, m_batt, ol, orr, ob, 1'b1, 1'b0);

        // Busy nxt pulses during a round, including one coincident with vld
        ol = m_lft; orr = m_rght; ob = m_batt;
        model_round(12'h555, 12'hAAA, 12'h5A5);
        run_round(12'h555, 12'hAAA, 12'h5A5, m_lft, m_rght, m_batt, ol, orr, ob, 1'b0, 1'b1);

        // Randomized rounds
        for (int i = 0; i < 3; i++) begin
            r0 = 12'($urandom); r4 = 12'($urandom); r5 = 12'($urandom);
            ol = m_lft; orr = m_rght; ob = m_batt;
            model_round(r0, r4, r5);
            run_round(r0, r4, r5, m_lft, m_rght, m_batt, ol, orr, ob, 1'b1, 1'b0);
        end

        // Reset in the middle of a frame
        adc_val[0] = 12'h777;
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        repeat (700) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        chk("post_rst_idle_ss_n", SS_n, 1'b1);
        chk("post_rst_vld_none", vld, 1'b0);

        // Filter sequence on ch0: 0x400, 0x000, 0x000
        for (int i = 0; i < 3; i++) begin
            r0 = (i == 0) ? 12'h400 : 12'h000;
            r4 = 12'($urandom); r5 = 12'($urandom);
            ol = m_lft; orr = m_rght; ob = m_batt;
            model_round(r0, r4, r5);
            run_round(r0, r4, r5, m_lft, m_rght, m_batt, ol, orr, ob, 1'b0, 1'b0);
            chk("filt_seq_lft", lft_ld, filt_exp[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
